// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trace_pkg
//  Description : Shared types and constants for the commit trace buffer.
//                The ABI name helper exists only when COMMIT_TRACE_FILE_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package trace_pkg;

    // One-hot memory access size encodings
    localparam logic [2:0] MEM_B = 3'b001;
    localparam logic [2:0] MEM_H = 3'b010;
    localparam logic [2:0] MEM_W = 3'b100;

    // Record layout for the default 32-bit / 7-bit-tag configuration
    localparam int REC_XLEN   = 32;
    localparam int REC_RADD_W = 7;

    typedef struct packed {
        logic [REC_XLEN-1:0]   pc;
        logic [REC_RADD_W-1:0] rd_add;
        logic [REC_XLEN-1:0]   rd_data;
        logic [2:0]            mem_wen;
        logic [REC_XLEN-1:0]   mem_wadd;
        logic [REC_XLEN-1:0]   mem_wdata;
        logic [REC_XLEN-1:0]   mem_radd;
    } trace_rec_t;

`ifdef COMMIT_TRACE_FILE_EN
    // RISC-V ABI register name for an architectural index
    function automatic string abi_name(input logic [4:0] idx);
        string names [32] = '{
            "zero", "ra", "sp", "gp", "tp", "t0", "t1", "t2",
            "s0", "s1", "a0", "a1", "a2", "a3", "a4", "a5",
            "a6", "a7", "s2", "s3", "s4", "s5", "s6", "s7",
            "s8", "s9", "s10", "s11", "t3", "t4", "t5", "t6"};
        return names[idx];
    endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/commit_trace_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : commit_trace_buffer_if
//  Description : Push, writeback and record-pop signals of the commit trace
//                buffer. master = pipeline/sink side, slave = buffer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface commit_trace_buffer_if #(
    parameter int NUM_WB = 2,
    parameter int XLEN   = 32,
    parameter int RADD_W = 7
);
    logic                     in_valid;
    logic                     in_ready;
    logic [XLEN-1:0]          in_pc;
    logic                     in_rd_en;
    logic [RADD_W-1:0]        in_rd_add;
    logic [2:0]               in_mem_ren;
    logic [2:0]               in_mem_wen;
    logic [XLEN-1:0]          in_mem_radd;
    logic [XLEN-1:0]          in_mem_wadd;
    logic [XLEN-1:0]          in_mem_wdata;

    logic [NUM_WB-1:0]        wb_en;
    logic [NUM_WB*RADD_W-1:0] wb_add;
    logic [NUM_WB*XLEN-1:0]   wb_data;

    logic                     out_valid;
    logic                     out_ready;
    logic [XLEN-1:0]          out_pc;
    logic [RADD_W-1:0]        out_rd_add;
    logic [XLEN-1:0]          out_rd_data;
    logic [2:0]               out_mem_wen;
    logic [XLEN-1:0]          out_mem_wadd;
    logic [XLEN-1:0]          out_mem_wdata;
    logic [XLEN-1:0]          out_mem_radd;
    logic [31:0]              inst_count;
    logic                     err_orphan;

    modport master (
        output in_valid, in_pc, in_rd_en, in_rd_add, in_mem_ren, in_mem_wen,
               in_mem_radd, in_mem_wadd, in_mem_wdata,
               wb_en, wb_add, wb_data, out_ready,
        input  in_ready, out_valid, out_pc, out_rd_add, out_rd_data,
               out_mem_wen, out_mem_wadd, out_mem_wdata, out_mem_radd,
               inst_count, err_orphan
    );

    modport slave (
        input  in_valid, in_pc, in_rd_en, in_rd_add, in_mem_ren, in_mem_wen,
               in_mem_radd, in_mem_wadd, in_mem_wdata,
               wb_en, wb_add, wb_data, out_ready,
        output in_ready, out_valid, out_pc, out_rd_add, out_rd_data,
               out_mem_wen, out_mem_wadd, out_mem_wdata, out_mem_radd,
               inst_count, err_orphan
    );
endinterface
`default_nettype wire

// File: rtl/trace_tag_table.sv
`default_nettype none
// ============================================================================
//  Module      : trace_tag_table
//  Description : Per-tag record of the newest buffer slot that will receive
//                that tag's writeback. One set port, NUM_WB combinational
//                read ports and NUM_WB clear ports; a set on a tag overrides
//                a clear of that tag in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_tag_table #(
    parameter int NUM_WB = 2,
    parameter int RADD_W = 7,
    parameter int IDX_W  = 4
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    input  wire logic                     set_en,
    input  wire logic [RADD_W-1:0]        set_tag,
    input  wire logic [IDX_W-1:0]         set_idx,
    input  wire logic [NUM_WB*RADD_W-1:0] rd_tag,
    output      logic [NUM_WB*IDX_W-1:0]  rd_idx,
    output      logic [NUM_WB-1:0]        rd_valid,
    input  wire logic [NUM_WB-1:0]        clr_en,
    input  wire logic [NUM_WB*RADD_W-1:0] clr_tag
);
    localparam int c_entries = 1 << RADD_W;

    logic [IDX_W-1:0]     r_last_idx [c_entries];
    logic [c_entries-1:0] r_valid;

    // Combinational lookups, one per writeback port
    generate
        for (genvar g = 0; g < NUM_WB; g++) begin : g_rd
            assign rd_idx[g*IDX_W +: IDX_W] = r_last_idx[rd_tag[g*RADD_W +: RADD_W]];
            assign rd_valid[g]              = r_valid[rd_tag[g*RADD_W +: RADD_W]];
        end
    endgenerate

    // Valid bits: clears first, then a set so it wins on a shared tag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_WB; i++) begin
                if (clr_en[i] && !(set_en && set_tag == clr_tag[i*RADD_W +: RADD_W])) begin
                    r_valid[clr_tag[i*RADD_W +: RADD_W]] <= 1'b0;
                end
            end
            if (set_en) begin
                r_valid[set_tag] <= 1'b1;
            end
        end
    end

    // Slot index payload needs no reset; it is qualified by the valid bit
    always_ff @(posedge clk) begin
        if (set_en) begin
            r_last_idx[set_tag] <= set_idx;
        end
    end
endmodule
`default_nettype wire

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : commit_trace_buffer
//  Description : In-order commit trace buffer. Captures register-write and
//                store events in program order, fills register results from
//                out-of-order writeback ports and emits complete records on
//                a valid/ready stream.
//                Optional: COMMIT_TRACE_FILE_EN prints every popped record
//                to the simulation log (simulation only).
//  Revision    : 1.0 - initial release
// ============================================================================
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int NUM_WB = 2,
    parameter int XLEN   = 32,
    parameter int RADD_W = 7
) (
    input wire logic              clk,
    input wire logic              reset,
    commit_trace_buffer_if.slave  bus
);
    localparam int                c_idx_w = $clog2(DEPTH);
    localparam logic [c_idx_w:0]  c_depth = (c_idx_w + 1)'(DEPTH);

    // Entry storage
    logic [XLEN-1:0]    r_pc        [DEPTH];
    logic [RADD_W-1:0]  r_rd_add    [DEPTH];
    logic [XLEN-1:0]    r_rd_data   [DEPTH];
    logic [2:0]         r_mem_wen   [DEPTH];
    logic [XLEN-1:0]    r_mem_wadd  [DEPTH];
    logic [XLEN-1:0]    r_mem_wdata [DEPTH];
    logic [XLEN-1:0]    r_mem_radd  [DEPTH];
    logic [DEPTH-1:0]   r_pending;

    logic [c_idx_w-1:0] r_wptr;
    logic [c_idx_w-1:0] r_head;
    logic [c_idx_w:0]   r_count;
    logic [31:0]        r_inst_count;
    logic               r_err_orphan;

    logic               w_vrd;
    logic               w_storable;
    logic               w_push;
    logic               w_pop;
    logic [XLEN-1:0]    w_wdata;

    logic [NUM_WB*c_idx_w-1:0] w_rd_idx_flat;
    logic [NUM_WB-1:0]         w_rd_valid;
    logic [c_idx_w-1:0]        w_idx [NUM_WB];
    logic [NUM_WB-1:0]         w_act;
    logic [NUM_WB-1:0]         w_win;
    logic [NUM_WB-1:0]         w_fill;
    logic [NUM_WB-1:0]         w_orphan;

    assign w_vrd      = bus.in_rd_en && (bus.in_rd_add[4:0] != 5'd0);
    assign w_storable = w_vrd || (bus.in_mem_wen != 3'b000);
    assign w_push     = bus.in_valid && bus.in_ready && w_storable && !reset;
    assign w_pop      = bus.out_valid && bus.out_ready && !reset;

    // Store data narrowed to the access size, lowest size bit taking priority
    always_comb begin
        w_wdata = '0;
        if ((bus.in_mem_wen & MEM_B) != 3'b000) begin
            w_wdata = {{(XLEN-8){1'b0}}, bus.in_mem_wdata[7:0]};
        end else if ((bus.in_mem_wen & MEM_H) != 3'b000) begin
            w_wdata = {{(XLEN-16){1'b0}}, bus.in_mem_wdata[15:0]};
        end else if ((bus.in_mem_wen & MEM_W) != 3'b000) begin
            w_wdata = bus.in_mem_wdata;
        end
    end

    trace_tag_table #(
        .NUM_WB (NUM_WB),
        .RADD_W (RADD_W),
        .IDX_W  (c_idx_w)
    ) u_tag_table (
        .clk      (clk),
        .reset    (reset),
        .set_en   (w_push && w_vrd),
        .set_tag  (bus.in_rd_add),
        .set_idx  (r_wptr),
        .rd_tag   (bus.wb_add),
        .rd_idx   (w_rd_idx_flat),
        .rd_valid (w_rd_valid),
        .clr_en   (w_fill),
        .clr_tag  (bus.wb_add)
    );

    // Writeback arbitration: highest port wins a shared tag, then hit/orphan
    always_comb begin
        for (int i = 0; i < NUM_WB; i++) begin
            w_act[i] = bus.wb_en[i] && (bus.wb_add[i*RADD_W +: 5] != 5'd0) && !reset;
        end
        for (int i = 0; i < NUM_WB; i++) begin
            w_win[i] = w_act[i];
            for (int j = i + 1; j < NUM_WB; j++) begin
                if (w_act[j] && bus.wb_add[j*RADD_W +: RADD_W] == bus.wb_add[i*RADD_W +: RADD_W]) begin
                    w_win[i] = 1'b0;
                end
            end
            w_idx[i]    = w_rd_idx_flat[i*c_idx_w +: c_idx_w];
            w_fill[i]   = w_win[i] && w_rd_valid[i] && r_pending[w_idx[i]]
                          && (r_rd_add[w_idx[i]] == bus.wb_add[i*RADD_W +: RADD_W]);
            w_orphan[i] = w_win[i] && !w_fill[i];
        end
    end

    // Pointers, occupancy, counters and pending flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr       <= '0;
            r_head       <= '0;
            r_count      <= '0;
            r_pending    <= '0;
            r_inst_count <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WB; i++) begin
                if (w_fill[i]) begin
                    r_pending[w_idx[i]] <= 1'b0;
                end
            end
            if (w_push) begin
                r_pending[r_wptr] <= w_vrd;
                r_wptr            <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_head       <= r_head + 1'b1;
                r_inst_count <= r_inst_count + 32'd1;
            end
            r_count <= r_count + (c_idx_w + 1)'(w_push) - (c_idx_w + 1)'(w_pop);
            if (w_orphan != '0) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    // Entry payloads; no reset, validity comes from the occupancy count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wptr]        <= bus.in_pc;
            r_rd_add[r_wptr]    <= w_vrd ? bus.in_rd_add : '0;
            r_rd_data[r_wptr]   <= '0;
            r_mem_wen[r_wptr]   <= bus.in_mem_wen;
            r_mem_wadd[r_wptr]  <= (bus.in_mem_wen != 3'b000) ? bus.in_mem_wadd : '0;
            r_mem_wdata[r_wptr] <= w_wdata;
            r_mem_radd[r_wptr]  <= (bus.in_mem_ren != 3'b000) ? bus.in_mem_radd : '0;
        end
        for (int i = 0; i < NUM_WB; i++) begin
            if (w_fill[i]) begin
                r_rd_data[w_idx[i]] <= bus.wb_data[i*XLEN +: XLEN];
            end
        end
    end

    assign bus.in_ready      = (r_count < c_depth);
    assign bus.out_valid     = (r_count != '0) && !r_pending[r_head];
    assign bus.out_pc        = r_pc[r_head];
    assign bus.out_rd_add    = r_rd_add[r_head];
    assign bus.out_rd_data   = r_rd_data[r_head];
    assign bus.out_mem_wen   = r_mem_wen[r_head];
    assign bus.out_mem_wadd  = r_mem_wadd[r_head];
    assign bus.out_mem_wdata = r_mem_wdata[r_head];
    assign bus.out_mem_radd  = r_mem_radd[r_head];
    assign bus.inst_count    = r_inst_count;
    assign bus.err_orphan    = r_err_orphan;

`ifdef COMMIT_TRACE_FILE_EN
    // Header at time 0
    initial begin
        $display("pc (rd name data) (wen wadd wdata | radd)");
    end

    // One line per popped record
    always @(posedge clk) begin
        if (w_pop) begin
            $display("%h (%0d %s %h) (%b %h %h | %h)",
                     bus.out_pc, bus.out_rd_add, abi_name(bus.out_rd_add[4:0]),
                     bus.out_rd_data, bus.out_mem_wen, bus.out_mem_wadd,
                     bus.out_mem_wdata, bus.out_mem_radd);
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_commit_trace_buffer
//  Description : Directed self-checking bench for commit_trace_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_buffer;
    localparam int DEPTH  = 16;
    localparam int NUM_WB = 2;
    localparam int XLEN   = 32;
    localparam int RADD_W = 7;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    commit_trace_buffer_if #(.NUM_WB(NUM_WB), .XLEN(XLEN), .RADD_W(RADD_W)) bus ();

    commit_trace_buffer #(
        .DEPTH  (DEPTH),
        .NUM_WB (NUM_WB),
        .XLEN   (XLEN),
        .RADD_W (RADD_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid     = 1'b0;
        bus.in_pc        = '0;
        bus.in_rd_en     = 1'b0;
        bus.in_rd_add    = '0;
        bus.in_mem_ren   = 3'b000;
        bus.in_mem_wen   = 3'b000;
        bus.in_mem_radd  = '0;
        bus.in_mem_wadd  = '0;
        bus.in_mem_wdata = '0;
        bus.wb_en        = '0;
        bus.wb_add       = '0;
        bus.wb_data      = '0;
    endtask

    task automatic push(input logic [31:0] pc, input logic rd_en, input logic [6:0] rd,
                        input logic [2:0] ren, input logic [31:0] radd,
                        input logic [2:0] wen, input logic [31:0] wadd, input logic [31:0] wdata);
        bus.in_valid     = 1'b1;
        bus.in_pc        = pc;
        bus.in_rd_en     = rd_en;
        bus.in_rd_add    = rd;
        bus.in_mem_ren   = ren;
        bus.in_mem_radd  = radd;
        bus.in_mem_wen   = wen;
        bus.in_mem_wadd  = wadd;
        bus.in_mem_wdata = wdata;
    endtask

    task automatic wb(input int port, input logic [6:0] tag, input logic [31:0] data);
        bus.wb_en[port]                 = 1'b1;
        bus.wb_add[port*RADD_W +: RADD_W] = tag;
        bus.wb_data[port*XLEN +: XLEN]    = data;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        idle();
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_inst_count", 64'(bus.inst_count), 64'd0);
        check_eq("rst_err_orphan", 64'(bus.err_orphan), 64'd0);

        // Store-only byte event, read info dropped because ren is 0
        push(32'h100, 1'b0, 7'd0, 3'b000, 32'h1234, 3'b001, 32'h2000, 32'hDEADBEEF);
        tick();
        idle();
        check_eq("st_valid", 64'(bus.out_valid), 64'd1);
        check_eq("st_pc", 64'(bus.out_pc), 64'h100);
        check_eq("st_wdata", 64'(bus.out_mem_wdata), 64'hEF);
        check_eq("st_rd_add", 64'(bus.out_rd_add), 64'd0);
        check_eq("st_wadd", 64'(bus.out_mem_wadd), 64'h2000);
        check_eq("st_radd", 64'(bus.out_mem_radd), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("st_count", 64'(bus.inst_count), 64'd1);
        check_eq("st_empty", 64'(bus.out_valid), 64'd0);

        // Pending head blocks a younger complete store
        push(32'h104, 1'b1, 7'd10, 3'b000, 32'h0, 3'b000, 32'h0, 32'h0);
        tick();
        push(32'h108, 1'b0, 7'd0, 3'b000, 32'h0, 3'b100, 32'h3000, 32'h12345678);
        tick();
        idle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("blk_no_rec", 64'(bus.out_valid), 64'd0);
            tick();
        end
        wb(0, 7'd10, 32'h55);
        tick();
        idle();
        check_eq("blk_valid", 64'(bus.out_valid), 64'd1);
        check_eq("blk_pc0", 64'(bus.out_pc), 64'h104);
        check_eq("blk_data0", 64'(bus.out_rd_data), 64'h55);
        check_eq("blk_rd0", 64'(bus.out_rd_add), 64'd10);
        tick();
        check_eq("blk_pc1", 64'(bus.out_pc), 64'h108);
        check_eq("blk_wdata1", 64'(bus.out_mem_wdata), 64'h12345678);
        tick();
        bus.out_ready = 1'b0;
        check_eq("blk_empty", 64'(bus.out_valid), 64'd0);
        check_eq("blk_count", 64'(bus.inst_count), 64'd3);

        // Same-tag push and writeback in one cycle fill the older entry
        push(32'h200, 1'b1, 7'd5, 3'b000, 32'h0, 3'b000, 32'h0, 32'h0);
        tick();
        push(32'h204, 1'b1, 7'd5, 3'b000, 32'h0, 3'b000, 32'h0, 32'h0);
        wb(0, 7'd5, 32'hA);
        tick();
        idle();
        wb(1, 7'd5, 32'hB);
        tick();
        idle();
        check_eq("tag_pc0", 64'(bus.out_pc), 64'h200);
        check_eq("tag_data0", 64'(bus.out_rd_data), 64'hA);
        bus.out_ready = 1'b1;
        tick();
        check_eq("tag_pc1", 64'(bus.out_pc), 64'h204);
        check_eq("tag_data1", 64'(bus.out_rd_data), 64'hB);
        check_eq("tag_valid1", 64'(bus.out_valid), 64'd1);
        tick();
        bus.out_ready = 1'b0;
        check_eq("tag_count", 64'(bus.inst_count), 64'd5);
        check_eq("tag_orphan", 64'(bus.err_orphan), 64'd0);

        // Fill to DEPTH, reject one more, then one pop frees a slot
        for (int i = 0; i < DEPTH; i++) begin
            push(32'h400 + 32'(4 * i), 1'b0, 7'd0, 3'b100, 32'h8, 3'b100, 32'h500, 32'(i));
            tick();
        end
        idle();
        check_eq("full_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("full_head", 64'(bus.out_pc), 64'h400);
        check_eq("full_radd", 64'(bus.out_mem_radd), 64'h8);
        push(32'h500, 1'b0, 7'd0, 3'b000, 32'h0, 3'b100, 32'h0, 32'h0);
        tick();
        idle();
        check_eq("full_still", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("full_freed", 64'(bus.in_ready), 64'd1);
        check_eq("full_next", 64'(bus.out_pc), 64'h404);
        bus.out_ready = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) tick();
        bus.out_ready = 1'b0;
        check_eq("full_drained", 64'(bus.out_valid), 64'd0);
        check_eq("full_count", 64'(bus.inst_count), 64'd21);

        // Write to x0 with no store is dropped
        push(32'h300, 1'b1, 7'd0, 3'b000, 32'h0, 3'b000, 32'h0, 32'h0);
        tick();
        idle();
        check_eq("x0_dropped", 64'(bus.out_valid), 64'd0);

        // Both ports on one tag: higher port wins without an orphan
        push(32'h600, 1'b1, 7'd9, 3'b000, 32'h0, 3'b000, 32'h0, 32'h0);
        tick();
        idle();
        wb(0, 7'd9, 32'h1);
        wb(1, 7'd9, 32'h2);
        tick();
        idle();
        check_eq("dual_valid", 64'(bus.out_valid), 64'd1);
        check_eq("dual_data", 64'(bus.out_rd_data), 64'h2);
        check_eq("dual_orphan", 64'(bus.err_orphan), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("dual_count", 64'(bus.inst_count), 64'd22);

        // Orphan writeback sets a sticky flag
        wb(1, 7'd7, 32'h77);
        tick();
        idle();
        check_eq("orph_set", 64'(bus.err_orphan), 64'd1);
        tick();
        tick();
        check_eq("orph_sticky", 64'(bus.err_orphan), 64'd1);

        // Reset mid-fill discards entries and tag state
        push(32'h700, 1'b1, 7'd12, 3'b000, 32'h0, 3'b000, 32'h0, 32'h0);
        tick();
        push(32'h704, 1'b0, 7'd0, 3'b000, 32'h0, 3'b001, 32'h0, 32'h0);
        tick();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mrst_valid", 64'(bus.out_valid), 64'd0);
        check_eq("mrst_orphan", 64'(bus.err_orphan), 64'd0);
        check_eq("mrst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("mrst_count", 64'(bus.inst_count), 64'd0);
        push(32'h800, 1'b0, 7'd0, 3'b100, 32'h44, 3'b010, 32'h900, 32'hCAFEBABE);
        tick();
        idle();
        check_eq("mrst_head_pc", 64'(bus.out_pc), 64'h800);
        check_eq("mrst_half", 64'(bus.out_mem_wdata), 64'hBABE);
        check_eq("mrst_radd", 64'(bus.out_mem_radd), 64'h44);
        wb(0, 7'd12, 32'h99);
        tick();
        idle();
        check_eq("mrst_tag_clr", 64'(bus.err_orphan), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
